// File: rtl/core_pkg.sv
// core_pkg: shared fetch constants and the fetch FSM state type.
package core_pkg;
    localparam logic [31:0] NOP_INSTR_C    = 32'h0000_0013;
    localparam logic [31:0] EBREAK_INSTR_C = 32'h0010_0073;
    localparam logic [31:0] RESET_PC_C     = 32'h0000_0000;
    typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t;
endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter with next-PC selection (redirect > advance > hold).
module pc_reg
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_C
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        advance_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_o
);
    logic [31:0] pc_next;
    always_comb
        pc_next = redirect_i ? {redirect_pc_i[31:2], 2'b00} : advance_i ? pc_o + 32'd4 : pc_o;
    always_ff @(posedge clk_i)
        pc_o <= !rst_i ? RESET_PC : pc_next;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with IF/ID register and BOOT/RUN/HALT control.
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_C,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] if_id_instr_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_pc4_o,
    output logic        if_id_valid_o,
    output logic        halted_o
);
    fetch_state_t state, state_next;
    logic redir, advance, bubble;
    always_comb begin
        redir      = redirect_i && state != BOOT;
        advance    = state == RUN && !redirect_i && !stall_i;
        bubble     = state != RUN || redirect_i;
        state_next = state == BOOT ? RUN :
                     redir ? RUN :
                     (advance && imem_data_i == EBREAK_INSTR_C) ? HALT : state;
    end
    pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .advance_i    (advance),
        .redirect_i   (redir),
        .redirect_pc_i(redirect_pc_i),
        .pc_o         (imem_addr_o)
    );
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state         <= BOOT;
            if_id_instr_o <= NOP_INSTR;
            if_id_pc_o    <= 32'd0;
            if_id_pc4_o   <= 32'd4;
            if_id_valid_o <= 1'b0;
        end else begin
            state <= state_next;
            if (bubble) begin
                if_id_instr_o <= NOP_INSTR;
                if_id_pc_o    <= 32'd0;
                if_id_pc4_o   <= 32'd4;
                if_id_valid_o <= 1'b0;
            end else if (!stall_i) begin
                if_id_instr_o <= imem_data_i;
                if_id_pc_o    <= imem_addr_o;
                if_id_pc4_o   <= imem_addr_o + 32'd4;
                if_id_valid_o <= 1'b1;
            end
        end
    end
    assign halted_o = state == HALT;
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, address fetched first after reset.
REQ-002 Parameter NOP_INSTR, 32'h0000_0013 (addi x0 x0 0), bubble inserted into IF/ID.
REQ-003 Port clk_i  input  1  single clock, all state updates on its rising edge.
REQ-004 Port rst_i  input  1  reset, synchronous, active-low.
REQ-005 Port imem_addr_o  output  32  fetch address driven to the instruction memory pc_i; equals the current PC.
REQ-006 Port imem_data_i  input  32  instruction word returned combinationally by the instruction memory for imem_addr_o.
REQ-007 Port stall_i  input  1  load-use hazard from decode; hold PC and IF/ID.
REQ-008 Port redirect_i  input  1  taken branch/jump resolved downstream; flush and redirect.
REQ-009 Port redirect_pc_i  input  32  redirect target address.
REQ-010 Port if_id_instr_o  output  32  registered instruction to decode.
REQ-011 Port if_id_pc_o  output  32  registered PC of if_id_instr_o.
REQ-012 Port if_id_pc4_o  output  32  registered if_id_pc_o + 4 (link value).
REQ-013 Port if_id_valid_o  output  1  IF/ID holds a real instruction.
REQ-014 Port halted_o  output  1  fetch is stopped in HALT.

Function
REQ-015 States SHALL be BOOT, RUN, HALT; BOOT is entered on reset.
REQ-016 BOOT SHALL last exactly one cycle, loading NOP into IF/ID with valid 0, then move to RUN; PC stays RESET_PC.
REQ-017 In RUN, per cycle priority SHALL be redirect_i > stall_i > normal advance.
REQ-018 Normal advance: PC <= PC + 4; IF/ID <= {imem_data_i, PC, PC+4, valid 1}.
REQ-019 Stall: PC and all IF/ID outputs SHALL hold their values.
REQ-020 Redirect: PC <= {redirect_pc_i[31:2], 2'b00}; IF/ID <= {NOP_INSTR, 0, 4, valid 0}; any concurrent stall_i is ignored.
REQ-021 First instruction from a redirect target SHALL appear in IF/ID one cycle after the redirect cycle (one-bubble penalty).
REQ-022 PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0; if_id_pc4_o wraps likewise.
REQ-023 RUN -> HALT when an advancing fetch captures imem_data_i == 32'h0010_0073 (ebreak); the ebreak itself enters IF/ID valid 1.
REQ-024 In HALT, PC SHALL freeze and IF/ID SHALL load NOP with valid 0 every cycle; halted_o = 1.
REQ-025 HALT -> RUN only on redirect_i, applying REQ-020 in that cycle; stall_i alone has no effect in HALT.
REQ-026 ebreak captured during a stall cycle or overridden by redirect SHALL NOT cause HALT.
REQ-027 imem_addr_o SHALL be purely PC, no combinational path from any input.

Reset
REQ-028 With rst_i low at a clock edge: PC <= RESET_PC, state <= BOOT, if_id_instr_o <= NOP_INSTR, if_id_pc_o <= 0, if_id_pc4_o <= 4, if_id_valid_o <= 0, halted_o <= 0.
REQ-029 Reset SHALL override redirect_i and stall_i and abort any state, including mid-stall and HALT.

Structure
REQ-030 Shared package core_pkg SHALL hold NOP_INSTR, EBREAK_INSTR, RESET_PC default and the fetch_state_t enum.
REQ-031 One sub-module pc_reg (PC register plus next-PC mux) is permitted; IF/ID register and FSM stay in fetch_stage.

Verification
REQ-032 Reset then 4 free-running cycles with memory holding 0x00a00093,0x00102023,... -> IF/ID valid from cycle 2, pc_o 0,4,8 in order.
REQ-033 stall_i high 2 cycles while IF/ID holds pc 8 -> pc_o stays 8, imem_addr_o stays 0xC, resumes with 0xC.
REQ-034 redirect_i with redirect_pc_i=0x20 and stall_i both high -> next cycle valid 0 NOP, following cycle pc_o 0x20.
REQ-035 redirect_pc_i=0x23 -> PC becomes 0x20.
REQ-036 ebreak at 0x10 -> captured valid, then halted_o 1, PC frozen; redirect to 0 -> halted_o 0, fetch from 0.
REQ-037 rst_i low during HALT and during a stall -> all outputs at REQ-028 values next cycle, fetch restarts at RESET_PC.
